// File: rtl/rmt_action_pkg.sv
// Shared action-word definitions for the RMT match-action ALU lanes:
// opcode encodings and the bit positions of each field in a lane action.
package rmt_action_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;

    // The op2 index and the immediate overlap; the opcode decides which applies.
    localparam int OPC_HI  = 24;
    localparam int OPC_LO  = 21;
    localparam int IDX1_HI = 20;
    localparam int IDX1_LO = 16;
    localparam int IDX2_HI = 15;
    localparam int IDX2_LO = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

endpackage

// File: rtl/issue_fifo.sv
// Small synchronous FIFO used to queue PHVs and action words ahead of issue.
// Push on full and pop on empty are prevented by the caller.
module issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Write the storage array on push.
    // NOTE: storage is not reset; emptiness lives in count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // Advance pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: pairs each PHV with its VLIW action word, selects two
// operands per lane, registers them towards the ALUs, and delays the source
// PHV so it meets the ALU results at the PHV-rebuild logic.
module alu_issue
    import rmt_action_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8,
    parameter int ALU_LAT    = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic                           phv_valid_in,
    output logic                           phv_ready_out,
    input  logic [NUM_CONT*ACTION_LEN-1:0] action_vec_in,
    input  logic                           action_valid_in,
    output logic                           action_ready_out,
    output logic [NUM_CONT*ACTION_LEN-1:0] alu_action_out,
    output logic [NUM_CONT-1:0]            alu_action_valid_out,
    output logic [NUM_CONT*DATA_WIDTH-1:0] alu_operand_1_out,
    output logic [NUM_CONT*DATA_WIDTH-1:0] alu_operand_2_out,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_delay_out,
    output logic                           phv_delay_valid_out
);

    localparam int PHV_W = NUM_CONT * DATA_WIDTH;
    localparam int ACT_W = NUM_CONT * ACTION_LEN;

    if (STAGE < 0 || NUM_CONT > 32 || NUM_CONT < 1 || ALU_LAT < 1 || ACTION_LEN < 25) begin : g_bad_cfg
        $error("alu_issue: unsupported parameter set");
    end

    logic             phv_full, phv_empty, act_full, act_empty;
    logic             phv_push, act_push, issue;
    logic [PHV_W-1:0] head_phv;
    logic [ACT_W-1:0] head_act;
    logic [PHV_W-1:0] op1_d, op2_d;

    // Readies are held low during reset so nothing is accepted into a flushing FIFO.
    assign phv_ready_out    = rst_n & ~phv_full;
    assign action_ready_out = rst_n & ~act_full;
    assign phv_push         = phv_valid_in & phv_ready_out;
    assign act_push         = action_valid_in & action_ready_out;
    assign issue            = ~phv_empty & ~act_empty;

    issue_fifo #(.WIDTH(PHV_W), .DEPTH(2)) u_phv_fifo (
        .clk(clk), .rst_n(rst_n), .push(phv_push), .pop(issue),
        .data(phv_in), .full(phv_full), .empty(phv_empty), .head(head_phv)
    );

    issue_fifo #(.WIDTH(ACT_W), .DEPTH(2)) u_act_fifo (
        .clk(clk), .rst_n(rst_n), .push(act_push), .pop(issue),
        .data(action_vec_in), .full(act_full), .empty(act_empty), .head(head_act)
    );

    // Container lookup; an index past the last container yields 0.
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [PHV_W-1:0] phv,
                                                   input logic [4:0] idx);
        pick = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (idx == 5'(i)) pick = phv[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    for (genvar k = 0; k < NUM_CONT; k++) begin : g_lane
        logic [ACTION_LEN-1:0] lane_act;
        logic [3:0]            opc;
        logic [4:0]            idx1, idx2;
        logic [15:0]           imm;
        logic [DATA_WIDTH-1:0] op1, op2;

        assign lane_act = head_act[k*ACTION_LEN +: ACTION_LEN];
        assign opc      = lane_act[OPC_HI:OPC_LO];
        assign idx1     = lane_act[IDX1_HI:IDX1_LO];
        assign idx2     = lane_act[IDX2_HI:IDX2_LO];
        assign imm      = lane_act[IMM_HI:IMM_LO];

        // Choose this lane's operands from its opcode class.
        // NOTE: both outputs get a default first, so no path through the case can infer a latch.
        always_comb begin
            op1 = '0;
            op2 = '0;
            case (opc)
                OP_ADD, OP_SUB: begin
                    op1 = pick(head_phv, idx1);
                    op2 = pick(head_phv, idx2);
                end
                OP_ADDI, OP_SUBI: begin
                    op1 = pick(head_phv, idx1);
                    op2 = DATA_WIDTH'(imm);
                end
                default: begin
                    op1 = head_phv[k*DATA_WIDTH +: DATA_WIDTH];
                    op2 = '0;
                end
            endcase
        end

        assign op1_d[k*DATA_WIDTH +: DATA_WIDTH] = op1;
        assign op2_d[k*DATA_WIDTH +: DATA_WIDTH] = op2;
    end

    logic [ACT_W-1:0] act_q;
    logic [PHV_W-1:0] op1_q, op2_q, phv_q;
    logic             vld_q;
    logic [PHV_W-1:0] dly_phv [ALU_LAT];
    logic [ALU_LAT-1:0] dly_vld;

    // Issue register bank; non-issue cycles load zeros rather than holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            phv_q <= '0;
            vld_q <= 1'b0;
        end else begin
            act_q <= issue ? head_act : '0;
            op1_q <= issue ? op1_d    : '0;
            op2_q <= issue ? op2_d    : '0;
            phv_q <= issue ? head_phv : '0;
            vld_q <= issue;
        end
    end

    // PHV delay line: ALU_LAT stages behind the issue registers, matching ALU latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_LAT; i++) dly_phv[i] <= '0;
            dly_vld <= '0;
        end else begin
            dly_phv[0] <= phv_q;
            for (int i = 1; i < ALU_LAT; i++) dly_phv[i] <= dly_phv[i-1];
            dly_vld <= {dly_vld[ALU_LAT-1:0], vld_q} >> 0 == '0 ? '0 : ALU_LAT'({dly_vld, vld_q});
        end
    end

    assign alu_action_out       = act_q;
    assign alu_action_valid_out = {NUM_CONT{vld_q}};
    assign alu_operand_1_out    = op1_q;
    assign alu_operand_2_out    = op2_q;
    assign phv_delay_out        = dly_phv[ALU_LAT-1];
    assign phv_delay_valid_out  = dly_vld[ALU_LAT-1];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, operand selection, FIFO pairing and
// backpressure, streaming throughput, and mid-stream asynchronous reset.
module tb_alu_issue;
    import rmt_action_pkg::*;

    localparam int NC  = 8;
    localparam int DW  = 48;
    localparam int AL  = 25;
    localparam int LAT = 3;
    localparam int PW  = NC * DW;
    localparam int AW  = NC * AL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] phv_in = '0;
    logic          phv_valid_in = 1'b0;
    logic          phv_ready_out;
    logic [AW-1:0] action_vec_in = '0;
    logic          action_valid_in = 1'b0;
    logic          action_ready_out;
    logic [AW-1:0] alu_action_out;
    logic [NC-1:0] alu_action_valid_out;
    logic [PW-1:0] alu_operand_1_out;
    logic [PW-1:0] alu_operand_2_out;
    logic [PW-1:0] phv_delay_out;
    logic          phv_delay_valid_out;

    int tests = 0;
    int fails = 0;

    alu_issue #(.STAGE(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in), .phv_ready_out(phv_ready_out),
        .action_vec_in(action_vec_in), .action_valid_in(action_valid_in),
        .action_ready_out(action_ready_out),
        .alu_action_out(alu_action_out), .alu_action_valid_out(alu_action_valid_out),
        .alu_operand_1_out(alu_operand_1_out), .alu_operand_2_out(alu_operand_2_out),
        .phv_delay_out(phv_delay_out), .phv_delay_valid_out(phv_delay_valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AL-1:0] lane(input logic [3:0] opc, input logic [4:0] i1,
                                           input logic [15:0] low);
        return {opc, i1, low};
    endfunction

    function automatic logic [PW-1:0] mk_phv(input logic [DW-1:0] base);
        logic [PW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*DW +: DW] = base + DW'(i);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_act"},   alu_action_out, '0);
        check({tag, "_vld"},   alu_action_valid_out, '0);
        check({tag, "_op1"},   alu_operand_1_out, '0);
        check({tag, "_op2"},   alu_operand_2_out, '0);
        check({tag, "_dly"},   phv_delay_out, '0);
        check({tag, "_dvld"},  phv_delay_valid_out, '0);
        check({tag, "_prdy"},  phv_ready_out, '0);
        check({tag, "_ardy"},  action_ready_out, '0);
    endtask

    logic [PW-1:0] p, pa, pb, pc, e1, e2;
    logic [AW-1:0] a;
    logic [PW-1:0] sp [6];
    logic [AW-1:0] sa [6];

    initial begin
        // ---- reset ----
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_rst_phv", phv_ready_out, 1);
        check("ready_after_rst_act", action_ready_out, 1);
        cyc();
        check("idle_vld", alu_action_valid_out, '0);
        check("idle_dvld", phv_delay_valid_out, 0);

        // ---- add on lane 2 ----
        p = mk_phv(48'h1000);
        p[0*DW +: DW] = 48'd10;
        p[1*DW +: DW] = 48'd3;
        a = '0;
        a[2*AL +: AL] = lane(OP_ADD, 5'd0, {5'd1, 11'd0});
        e1 = p;
        e1[2*DW +: DW] = 48'd10;
        e2 = '0;
        e2[2*DW +: DW] = 48'd3;
        phv_in = p; action_vec_in = a; phv_valid_in = 1; action_valid_in = 1;   // cycle t
        cyc();                                                                      // t+1
        phv_valid_in = 0; action_valid_in = 0;
        check("add_t1_vld", alu_action_valid_out, '0);
        cyc();                                                                      // t+2
        check("add_vld", alu_action_valid_out, 8'hFF);
        check("add_l2_op1", alu_operand_1_out[2*DW +: DW], 48'd10);
        check("add_l2_op2", alu_operand_2_out[2*DW +: DW], 48'd3);
        check("add_op1", alu_operand_1_out, e1);
        check("add_op2", alu_operand_2_out, e2);
        check("add_act", alu_action_out, a);
        cyc();                                                                      // t+3
        check("add_t3_vld", alu_action_valid_out, '0);
        check("add_t3_op1_zero", alu_operand_1_out, '0);
        check("add_t3_act_zero", alu_action_out, '0);
        check("add_t3_dvld", phv_delay_valid_out, 0);
        cyc();                                                                      // t+4
        check("add_t4_dvld", phv_delay_valid_out, 0);
        cyc();                                                                      // t+5
        check("add_t5_dvld", phv_delay_valid_out, 1);
        check("add_t5_dly", phv_delay_out, p);
        cyc();                                                                      // t+6
        check("add_t6_dvld", phv_delay_valid_out, 0);

        // ---- subi, out-of-range index, no-op lanes ----
        p = mk_phv(48'h2000);
        p[4*DW +: DW] = 48'h500;
        a = '0;
        a[0*AL +: AL] = lane(OP_SUBI, 5'd4, 16'h0100);
        a[1*AL +: AL] = lane(OP_ADD, 5'd31, {5'd4, 11'd0});
        a[5*AL +: AL] = lane(4'b0000, 5'd2, 16'hFFFF);
        a[7*AL +: AL] = lane(OP_SUB, 5'd7, {5'd31, 11'd0});
        e1 = p;
        e1[0*DW +: DW] = 48'h500;
        e1[1*DW +: DW] = '0;
        e2 = '0;
        e2[0*DW +: DW] = 48'h100;
        e2[1*DW +: DW] = 48'h500;
        phv_in = p; action_vec_in = a; phv_valid_in = 1; action_valid_in = 1;
        cyc();
        phv_valid_in = 0; action_valid_in = 0;
        cyc();
        check("subi_l0_op1", alu_operand_1_out[0*DW +: DW], 48'h500);
        check("subi_l0_op2", alu_operand_2_out[0*DW +: DW], 48'h100);
        check("idx31_l1_op1", alu_operand_1_out[1*DW +: DW], '0);
        check("nop_l5_op1", alu_operand_1_out[5*DW +: DW], 48'h2005);
        check("nop_l5_op2", alu_operand_2_out[5*DW +: DW], '0);
        check("idx31_l7_op2", alu_operand_2_out[7*DW +: DW], '0);
        check("mix_op1", alu_operand_1_out, e1);
        check("mix_op2", alu_operand_2_out, e2);
        repeat (5) cyc();

        // ---- PHVs ahead of actions, FIFO full ----
        pa = mk_phv(48'hA000);
        pb = mk_phv(48'hB000);
        pc = mk_phv(48'hC000);
        phv_in = pa; phv_valid_in = 1; action_vec_in = '0;                         // t
        cyc();                                                                      // t+1
        check("lag_t1_vld", alu_action_valid_out, '0);
        phv_in = pb;
        cyc();                                                                      // t+2
        check("lag_full_ready", phv_ready_out, 0);
        check("lag_act_ready", action_ready_out, 1);
        check("lag_t2_vld", alu_action_valid_out, '0);
        phv_in = pc; action_valid_in = 1;
        cyc();                                                                      // t+3
        check("lag_t3_vld", alu_action_valid_out, '0);
        check("lag_t3_ready", phv_ready_out, 0);
        phv_valid_in = 0; action_valid_in = 0;
        cyc();                                                                      // t+4
        check("lag_a_vld", alu_action_valid_out, 8'hFF);
        check("lag_a_op1", alu_operand_1_out, pa);
        check("lag_t4_ready", phv_ready_out, 1);
        action_valid_in = 1;
        cyc();                                                                      // t+5
        check("lag_t5_vld", alu_action_valid_out, '0);
        action_valid_in = 0;
        cyc();                                                                      // t+6
        check("lag_b_vld", alu_action_valid_out, 8'hFF);
        check("lag_b_op1", alu_operand_1_out, pb);
        cyc();
        check("lag_t7_vld", alu_action_valid_out, '0);
        repeat (6) cyc();

        // ---- back-to-back stream of 6 ----
        for (int i = 0; i < 6; i++) begin
            sp[i] = mk_phv(48'h100000 * 48'(i + 1));
            sa[i] = '0;
            sa[i][0*AL +: AL] = lane(OP_ADDI, 5'd0, 16'(i + 1) * 16'h11);
        end
        for (int c = 0; c < 12; c++) begin
            if (c >= 2 && c < 8) begin
                check("strm_vld", alu_action_valid_out, 8'hFF);
                check("strm_op1", alu_operand_1_out, sp[c-2]);
                check("strm_imm", alu_operand_2_out[0*DW +: DW], 48'(16'(c - 1) * 16'h11));
            end else begin
                check("strm_idle_vld", alu_action_valid_out, '0);
            end
            if (c >= 5 && c < 11) begin
                check("strm_dvld", phv_delay_valid_out, 1);
                check("strm_dly", phv_delay_out, sp[c-5]);
            end else begin
                check("strm_idle_dvld", phv_delay_valid_out, 0);
            end
            if (c < 6) begin
                check("strm_ready", phv_ready_out, 1);
                phv_in = sp[c]; action_vec_in = sa[c];
                phv_valid_in = 1; action_valid_in = 1;
            end else begin
                phv_valid_in = 0; action_valid_in = 0;
            end
            cyc();
        end

        // ---- reset mid-stream ----
        for (int c = 0; c < 4; c++) begin
            phv_in = sp[c]; action_vec_in = sa[c];
            phv_valid_in = 1; action_valid_in = 1;
            cyc();
        end
        check("pre_rst_vld", alu_action_valid_out, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        phv_valid_in = 0; action_valid_in = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check("post_rst_vld", alu_action_valid_out, '0);
            check("post_rst_dvld", phv_delay_valid_out, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that drives the ALU lanes of one RMT match-action stage. It pairs each incoming PHV with its VLIW action word and splits the word into per-container actions. It selects two operands per lane from the PHV containers or an immediate, and presents `action`/`action_valid`/`operand_1`/`operand_2` to NUM_CONT ALUs. It also delays the source PHV so that it arrives at the PHV-rebuild logic in the same cycle as the ALU results.

## Interface
- `STAGE`, 0, stage index (informational).
- `ACTION_LEN`, 25, bits per lane action.
- `DATA_WIDTH`, 48, container width.
- `NUM_CONT`, 8, containers per PHV and ALU lanes (≤32).
- `ALU_LAT`, 3, ALU latency in cycles (action_valid to container_out_valid).
- `clk` in 1, single clock; all logic on posedge.
- `rst_n` in 1, asynchronous active-low reset.
- `phv_in` in NUM_CONT*DATA_WIDTH, PHV; container k is at [k*DATA_WIDTH +: DATA_WIDTH].
- `phv_valid_in` in 1, PHV strobe; accepted when `phv_ready_out`=1.
- `phv_ready_out` out 1, PHV FIFO not full.
- `action_vec_in` in NUM_CONT*ACTION_LEN, VLIW word; lane k is at [k*ACTION_LEN +: ACTION_LEN].
- `action_valid_in` in 1, action strobe; accepted when `action_ready_out`=1.
- `action_ready_out` out 1, action FIFO not full.
- `alu_action_out` out NUM_CONT*ACTION_LEN, per-lane action.
- `alu_action_valid_out` out NUM_CONT, per-lane valid.
- `alu_operand_1_out` / `alu_operand_2_out` out NUM_CONT*DATA_WIDTH, per-lane operands.
- `phv_delay_out` out NUM_CONT*DATA_WIDTH, source PHV aligned with the ALU outputs.
- `phv_delay_valid_out` out 1, valid for `phv_delay_out`.

## Operation
- Two 2-entry FIFOs, one for PHVs and one for actions. PHVs and actions arrive independently but in the same order. The n-th accepted PHV pairs with the n-th accepted action.
- Ready outputs are combinational `!full`. Both are 0 while `rst_n`=0. A push and a pop on a full FIFO in the same cycle is not allowed; ready already reflects full.
- Issue happens in any cycle where both FIFOs are non-empty. Both heads are popped together. There is no downstream backpressure because the ALUs are fixed-latency.
- Lane action fields: [24:21] opcode, [20:16] op1 index, [15:11] op2 index, [15:0] immediate.
- Per-lane operand selection, with C[i] = container i of the head PHV:
  - Opcode 0001/0010 (add/sub): op1=C[op1_idx], op2=C[op2_idx].
  - Opcode 1001/1010 (addi/subi): op1=C[op1_idx], op2=zero-extended immediate.
  - Any other opcode (no-op/default): op1=C[k], op2=0. The ALU then passes its own container through unchanged.
- An index ≥ NUM_CONT selects 0 for that operand.
- `alu_action_out` lane k is the head action lane k, unmodified. On issue, all NUM_CONT lane valids are 1; otherwise all are 0.
- A non-issue cycle drives actions and operands to 0, not held.
- PHV delay line: a shift register of ALU_LAT stages, loaded on issue with the head PHV and valid=1. A non-issue cycle shifts in 0/valid=0.

## Timing
- Reset: FIFOs empty and all issue/delay registers 0. Every output is 0, including both readies.
- First ready is 1 in the first cycle after reset deasserts.
- A PHV and action both pushed at cycle t into empty FIFOs issue at t+1. Registered ALU outputs are valid at t+2.
- `phv_delay_valid_out` rises at t+2+ALU_LAT, the same cycle the ALU `container_out_valid` rises.
- Sustained throughput is one issue per cycle when both inputs stream every cycle.
- A PHV arriving k cycles before its action issues in the cycle after the action is pushed.
- Asynchronous reset mid-operation flushes the FIFOs and the delay line immediately. In-flight entries are dropped; no partial output appears.

## Structure
- Shared package `rmt_action_pkg`:
  - Opcode constants (OP_ADD=4'b0001, OP_SUB=4'b0010, OP_ADDI=4'b1001, OP_SUBI=4'b1010).
  - Field positions: OPC_HI/LO, IDX1_HI/LO, IDX2_HI/LO, IMM_HI/LO.
- Sub-module `issue_fifo`:
  - Parameters WIDTH and DEPTH=2.
  - Ports push/pop/full/empty/head; async active-low reset.
  - Instantiated twice, once for PHVs and once for actions.
- Operand muxes are per-lane generate loops in the top module.

## Test plan
- Reset then idle: all outputs 0. Readies are 0 during reset and 1 afterwards.
- PHV with C0=10, C1=3 and lane 2 action {0001, idx1=0, idx2=1}, both pushed at t. At t+2, lane 2 has op1=10, op2=3 and valid=1. `phv_delay_valid_out`=1 at t+5.
- Lane 0 action {1010, idx1=4, imm=16'h0100} with C4=48'h500. Lane 0 has op1=48'h500, op2=48'h100.
- Action pushed 2 cycles after its PHV: no issue until the action lands, then a single issue. A third PHV pushed while 2 are queued without actions sees `phv_ready_out`=0.
- Index 31 with NUM_CONT=8: that operand is 0. Opcode 0000 on lane 5: op1=C5, op2=0.
- Back-to-back stream of 6 pairs: 6 consecutive valid issues in order. Assert `rst_n` low mid-stream: all outputs are 0 at once and no further valids appear after release.
